// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the serial adder/subtractor.
package serial_addsub_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of DIGIT-wide beats needed to cover a WIDTH-bit operand.
  function automatic int unsigned calc_beats(input int unsigned width,
                                             input int unsigned digit);
    return width / digit;
  endfunction

  // Beat counter width; at least one bit even for a single-beat operation.
  function automatic int unsigned calc_cnt_w(input int unsigned width,
                                             input int unsigned digit);
    int unsigned beats;
    beats = width / digit;
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Requester side: issues operands, consumes results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple-carry chain of full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] sum_c_o,
  output logic             co_c_o,
  output logic             cmsb_c_o
);

  logic carry_c;

  // Ripple the carry bit by bit; capture the carry entering the top cell for overflow.
  always_comb begin
    carry_c  = c_i;
    sum_c_o  = '0;
    cmsb_c_o = c_i;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (i == int'(DIGIT) - 1) begin
        cmsb_c_o = carry_c;
      end
      sum_c_o[i] = a_i[i] ^ b_i[i] ^ carry_c;
      carry_c    = (a_i[i] & b_i[i]) | (carry_c & (a_i[i] ^ b_i[i]));
    end
    co_c_o = carry_c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: DIGIT bits per beat, LSB digit first, carry held between beats.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_addsub_if.slave bus
);

  localparam int unsigned BEATS = calc_beats(WIDTH, DIGIT);
  localparam int unsigned CNT_W = calc_cnt_w(WIDTH, DIGIT);

  localparam logic [STATE_W-1:0] IDLE = STATE_W'(ST_IDLE);
  localparam logic [STATE_W-1:0] RUN  = STATE_W'(ST_RUN);
  localparam logic [STATE_W-1:0] DONE = STATE_W'(ST_DONE);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [DIGIT-1:0]       dsum_c;
  logic                   dco_c;
  logic                   dcmsb_c;
  logic [WIDTH+DIGIT-1:0] res_cat_c;
  logic [WIDTH-1:0]       res_shift_c;
  logic                   last_beat_c;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a_i      (opa_q[DIGIT-1:0]),
    .b_i      (opb_q[DIGIT-1:0]),
    .c_i      (carry_q),
    .sum_c_o  (dsum_c),
    .co_c_o   (dco_c),
    .cmsb_c_o (dcmsb_c)
  );

  // New digit enters at the top of the result register, older digits move down.
  always_comb begin
    res_cat_c   = {dsum_c, res_q};
    res_shift_c = WIDTH'(res_cat_c >> DIGIT);
    last_beat_c = (cnt_q == CNT_W'(BEATS - 1));
  end

  // Next-state and datapath update for IDLE -> RUN -> DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_d       = res_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? ~bus.cin : bus.cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        res_d   = res_shift_c;
        carry_d = dco_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_beat_c) begin
          sum_d   = res_shift_c;
          cout_d  = dco_c;
          ovf_d   = dco_c ^ dcmsb_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle adder/subtractor. It processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, and holds a ripple carry in a register between beats. It supports add and subtract modes, carry/borrow-in, carry-out and signed-overflow flags. Operands enter and results leave through valid/ready handshakes, so the block can sit between register-file or datapath stages where area matters more than single-cycle latency.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per beat.
  - Must divide WIDTH.
  - Legal range 1..WIDTH.
  - BEATS = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept an operand set.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode) or borrow-in (subtract mode).
- sub  in  1  0 selects A+B+cin; 1 selects A-B-cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of the MSB; in subtract mode 1 means no borrow.
- ovf  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

## Operation
FSM states: IDLE, RUN, DONE.

- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid at a rising edge, capture:
    - opA = a
    - opB = sub ? ~b : b
    - carry = sub ? ~cin : cin
  - Clear beat counter; go to RUN.
- RUN
  - in_ready=0; in_valid ignored; a/b/cin/sub may change freely.
  - Each beat: add the low DIGIT bits of opA and opB plus carry.
  - Shift opA and opB right by DIGIT.
  - Shift the digit result into the top of the result register (right shift).
  - Register the carry out.
  - On the last beat (counter = BEATS-1), also register ovf (carry into MSB XOR carry out) and cout; go to DONE.
- DONE
  - out_valid=1; sum/cout/ovf stable.
  - Go to IDLE when out_ready=1 at a rising edge.
  - With out_ready held low, stay indefinitely; outputs must not change.
- Arithmetic
  - Subtraction computes A + ~B + (1-cin), i.e. A-B-cin mod 2^WIDTH.
  - No result saturation.
- Reset (asynchronous, any state including mid-RUN)
  - State IDLE; in_ready=1, out_valid=0, sum=0, cout=0, ovf=0; internal registers cleared.
  - An aborted operation produces no output.
- sum/cout/ovf hold their last result while in IDLE and RUN.
  - They update only on the transition into DONE.

## Timing
- Acceptance edge E0 (in_valid & in_ready).
- Beats occur at edges E1..E_BEATS.
- out_valid is high from edge E_BEATS onward.
- Latency = BEATS cycles from acceptance to out_valid.
- No overlap of operations:
  - Earliest IDLE return is E_BEATS+1 (out_ready high).
  - Earliest next acceptance is E_BEATS+2.
  - Minimum initiation interval is BEATS+2 cycles.
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- DIGIT=WIDTH: BEATS=1, a single RUN cycle.
- DIGIT=1: fully bit-serial, BEATS=WIDTH.

## Structure
- Shared package serial_addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing BEATS and counter width ($clog2(BEATS), minimum 1).
- One sub-module, digit_adder:
  - combinational DIGIT-bit ripple chain of full-adder cells;
  - outputs digit sum, carry out, and carry into the digit MSB (used for ovf on the last beat).
- The top level holds the FSM, beat counter, operand/result shift registers, carry register and flag registers.

## Test plan
All cases use WIDTH=16, DIGIT=4 unless noted.
- a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 edges after acceptance.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract mode:
  - a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, cin=0, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
  - a=0x0010, b=0x0001, cin=1, sub=1 -> sum=0x000E.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a -> sum stable, in_ready=0, nothing accepted.
  - Release out_ready -> next operand accepted 2 edges later.
- Assert rst during the second RUN beat -> out_valid stays 0, in_ready=1, sum=0.
  - The next operation (0x0001+0x0001) returns 0x0002.
- Repeat the first three scenarios with DIGIT=1 (latency 16) and DIGIT=16 (latency 1) -> identical results.
- Random regression of 10k operands against a reference model.
